j1_boot_loader: RTL and testbench

J1_BOOT_LOADER -- requirements
Module: j1_boot_loader

---
 rtl/j1_boot_loader_pkg.sv | 30 +++
 rtl/j1_boot_loader_spi_shift8.sv | 89 ++++++++
 rtl/j1_boot_loader.sv | 209 ++++++++++++++++++++
 tb/tb_j1_boot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/j1_boot_loader_pkg.sv
// Shared definitions for the J1 boot loader: loader FSM states, SPI flash
// opcodes and the read-command byte sequencer.
package j1_boot_loader_pkg;

    typedef enum logic [2:0] {
        WAKE     = 3'd0,
        WAKE_GAP = 3'd1,
        CMD      = 3'd2,
        DATA     = 3'd3,
        FINISH   = 3'd4,
        RUN      = 3'd5
    } boot_state_t;

    localparam logic [7:0] SPI_WAKE = 8'hAB;
    localparam logic [7:0] SPI_READ = 8'h03;

    // Byte idx of the read command: opcode, then the 24-bit address MSB first.
    function automatic logic [7:0] read_cmd_byte(input logic [1:0] idx, input logic [23:0] base);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SPI_READ;
            2'd1:    b = base[23:16];
            2'd2:    b = base[15:8];
            2'd3:    b = base[7:0];
            default: b = SPI_READ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/j1_boot_loader_spi_shift8.sv
// SPI mode-0 8-bit full-duplex shifter. A start accepted in the cycle that
// done is high chains the next byte with no gap on the wire.
module spi_shift8 #(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       mosi
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    logic          busy_r;
    logic          sck_r;
    logic          mosi_r;
    logic [7:0]    shreg_r;
    logic [7:0]    rx_r;
    logic [2:0]    bit_cnt_r;
    logic [DW-1:0] div_cnt_r;
    logic          edge_s;
    logic          done_s;

    assign edge_s = busy_r && (div_cnt_r == DIV_LAST);
    // Last cycle of the 8th bit's high phase: rx_byte is complete here.
    assign done_s = edge_s && sck_r && (bit_cnt_r == 3'd7);

    // Prescaler, SCK generation, MOSI launch on falling edges, MISO capture on rising edges.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            busy_r    <= 1'b0;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            shreg_r   <= 8'h00;
            rx_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            div_cnt_r <= '0;
        end else if (!busy_r) begin
            div_cnt_r <= '0;
            sck_r     <= 1'b0;
            if (start) begin
                busy_r    <= 1'b1;
                shreg_r   <= tx_byte;
                mosi_r    <= tx_byte[7];
                bit_cnt_r <= 3'd0;
            end else begin
                mosi_r    <= 1'b0;
            end
        end else if (!edge_s) begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end else begin
            div_cnt_r <= '0;
            if (!sck_r) begin
                sck_r <= 1'b1;
                rx_r  <= {rx_r[6:0], miso};
            end else begin
                sck_r <= 1'b0;
                if (bit_cnt_r == 3'd7) begin
                    if (start) begin
                        shreg_r   <= tx_byte;
                        mosi_r    <= tx_byte[7];
                        bit_cnt_r <= 3'd0;
                    end else begin
                        busy_r <= 1'b0;
                        mosi_r <= 1'b0;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    shreg_r   <= {shreg_r[6:0], 1'b0};
                    mosi_r    <= shreg_r[6];
                end
            end
        end
    end

    assign rx_byte = rx_r;
    assign busy    = busy_r;
    assign done    = done_s;
    assign sck     = sck_r;
    assign mosi    = mosi_r;

endmodule

// File: rtl/j1_boot_loader.sv
// Boot loader for the J1: wakes the SPI flash, streams the code image into
// RAM as little-endian 16-bit words, then releases the CPU from reset.
module j1_boot_loader
    import j1_boot_loader_pkg::*;
#(
    parameter int          WORDS      = 8192,
    parameter logic [23:0] FLASH_BASE = 24'h020000,
    parameter int          CLKDIV     = 2,
    parameter int          TWAKE      = 64
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        reload_req,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        cpu_resetq,
    output logic        done
);

    localparam int GW = $clog2(TWAKE + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TWAKE - 1);
    localparam logic [12:0]   ADDR_LAST = 13'(WORDS - 1);

    boot_state_t state_r;
    boot_state_t state_nxt_s;

    logic          cs_n_r;
    logic          cs_n_nxt_s;
    logic          start_s;
    logic [7:0]    tx_s;
    logic [GW-1:0] gap_cnt_r;
    logic [1:0]    byte_cnt_r;
    logic          odd_r;
    logic [7:0]    lo_r;
    logic [12:0]   ram_addr_r;
    logic [15:0]   ram_wdata_r;
    logic          ram_we_r;
    logic          cpu_resetq_r;
    logic          done_r;

    logic          miso_s;
    logic [7:0]    sh_rx_s;
    logic          sh_busy_s;
    logic          sh_done_s;
    logic          last_word_s;

    // MISO only reaches the shifter while image data is being streamed.
    assign miso_s      = (state_r == DATA) ? spi_miso : 1'b0;
    assign last_word_s = odd_r && (ram_addr_r == ADDR_LAST);

    spi_shift8 #(.CLKDIV(CLKDIV)) u_shift (
        .clk     (clk),
        .resetq  (resetq),
        .start   (start_s),
        .tx_byte (tx_s),
        .miso    (miso_s),
        .rx_byte (sh_rx_s),
        .busy    (sh_busy_s),
        .done    (sh_done_s),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_r <= WAKE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAKE: begin
                if (sh_done_s) state_nxt_s = WAKE_GAP;
                else           state_nxt_s = WAKE;
            end
            WAKE_GAP: begin
                if (gap_cnt_r == GAP_LAST) state_nxt_s = CMD;
                else                       state_nxt_s = WAKE_GAP;
            end
            CMD: begin
                if (sh_done_s && (byte_cnt_r == 2'd3)) state_nxt_s = DATA;
                else                                   state_nxt_s = CMD;
            end
            DATA: begin
                if (sh_done_s && last_word_s) state_nxt_s = FINISH;
                else                          state_nxt_s = DATA;
            end
            FINISH: state_nxt_s = RUN;
            RUN: begin
                if (reload_req) state_nxt_s = WAKE;
                else            state_nxt_s = RUN;
            end
            default: state_nxt_s = WAKE;
        endcase
    end

    // Shifter launch/chaining and next chip-select level.
    always_comb begin
        start_s    = 1'b0;
        tx_s       = 8'h00;
        cs_n_nxt_s = 1'b1;
        case (state_r)
            WAKE: begin
                if (!sh_busy_s) begin
                    start_s    = 1'b1;
                    tx_s       = SPI_WAKE;
                    cs_n_nxt_s = 1'b0;
                end else if (sh_done_s) begin
                    cs_n_nxt_s = 1'b1;
                end else begin
                    cs_n_nxt_s = 1'b0;
                end
            end
            WAKE_GAP: begin
                // The opcode launches in the last gap cycle so CS falls exactly TWAKE cycles after it rose.
                if (gap_cnt_r == GAP_LAST) begin
                    start_s    = 1'b1;
                    tx_s       = SPI_READ;
                    cs_n_nxt_s = 1'b0;
                end else begin
                    cs_n_nxt_s = 1'b1;
                end
            end
            CMD: begin
                cs_n_nxt_s = 1'b0;
                if (sh_done_s) begin
                    start_s = 1'b1;
                    if (byte_cnt_r == 2'd3) tx_s = 8'h00;
                    else                    tx_s = read_cmd_byte(byte_cnt_r + 2'd1, FLASH_BASE);
                end else begin
                    start_s = 1'b0;
                end
            end
            DATA: begin
                if (sh_done_s && last_word_s) begin
                    cs_n_nxt_s = 1'b1;
                end else if (sh_done_s) begin
                    start_s    = 1'b1;
                    cs_n_nxt_s = 1'b0;
                end else begin
                    cs_n_nxt_s = 1'b0;
                end
            end
            FINISH:  cs_n_nxt_s = 1'b1;
            RUN:     cs_n_nxt_s = 1'b1;
            default: cs_n_nxt_s = 1'b1;
        endcase
    end

    // Registered outputs, gap/byte counters and word assembly.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cs_n_r       <= 1'b1;
            gap_cnt_r    <= '0;
            byte_cnt_r   <= 2'd0;
            odd_r        <= 1'b0;
            lo_r         <= 8'h00;
            ram_addr_r   <= 13'd0;
            ram_wdata_r  <= 16'h0000;
            ram_we_r     <= 1'b0;
            cpu_resetq_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            cs_n_r       <= cs_n_nxt_s;
            cpu_resetq_r <= (state_nxt_s == RUN);
            done_r       <= (state_nxt_s == RUN);

            if (state_r == WAKE_GAP) gap_cnt_r <= gap_cnt_r + GW'(1);
            else                     gap_cnt_r <= '0;

            if (state_r == WAKE_GAP)            byte_cnt_r <= 2'd0;
            else if (state_r == CMD && sh_done_s) byte_cnt_r <= byte_cnt_r + 2'd1;
            else                                 byte_cnt_r <= byte_cnt_r;

            if (state_r == DATA && sh_done_s) begin
                if (!odd_r) lo_r <= sh_rx_s;
                else        ram_wdata_r <= {sh_rx_s, lo_r};
                ram_we_r <= odd_r;
                odd_r    <= ~odd_r;
            end else begin
                ram_we_r <= 1'b0;
                if (state_r != DATA) odd_r <= 1'b0;
            end

            // Address advances after each write and parks on the last word.
            if (state_r == RUN && reload_req)             ram_addr_r <= 13'd0;
            else if (ram_we_r && ram_addr_r != ADDR_LAST) ram_addr_r <= ram_addr_r + 13'd1;
            else                                          ram_addr_r <= ram_addr_r;
        end
    end

    assign spi_cs_n   = cs_n_r;
    assign ram_addr   = ram_addr_r;
    assign ram_wdata  = ram_wdata_r;
    assign ram_we     = ram_we_r;
    assign cpu_resetq = cpu_resetq_r;
    assign done       = done_r;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Directed bench for j1_boot_loader with a behavioural SPI read-only flash.
module tb_j1_boot_loader;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        reload_req = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sck, spi_mosi, ram_we, cpu_resetq, done;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0]  flash_mem [0:7];
    logic [15:0] exp_word  [0:3];

    logic [7:0]  mosi_log [0:63];
    int          mosi_cnt = 0;
    int          fl_bits = 0;
    logic [7:0]  fl_in = 8'h00;

    logic [12:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    logic        wr_cs   [0:63];
    int          wr_cnt = 0;
    int          sck_edges = 0;
    int          done_rise_cyc = 0;
    logic        done_q = 1'b0;

    j1_boot_loader #(
        .WORDS(4), .FLASH_BASE(24'h020000), .CLKDIV(1), .TWAKE(8)
    ) dut (
        .clk(clk), .resetq(resetq), .reload_req(reload_req), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cpu_resetq(cpu_resetq), .done(done)
    );

    always #5 clk = ~clk;

    // Flash model: shift in command bytes on SCK rise, CS high restarts the transaction.
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            fl_bits = 0;
        end else begin
            if (fl_bits < 32) begin
                fl_in = {fl_in[6:0], spi_mosi};
                if (fl_bits % 8 == 7 && mosi_cnt < 64) begin
                    mosi_log[mosi_cnt] = fl_in;
                    mosi_cnt = mosi_cnt + 1;
                end
            end
            fl_bits = fl_bits + 1;
        end
    end

    // Flash model: data bits launched on SCK fall; idle-high MISO outside the data phase.
    always @(negedge spi_sck) begin
        if (!spi_cs_n && fl_bits >= 32) begin
            int idx;
            idx = fl_bits - 32;
            spi_miso = flash_mem[(idx / 8) % 8][7 - (idx % 8)];
        end else begin
            spi_miso = 1'b1;
        end
    end

    always @(posedge spi_sck) sck_edges = sck_edges + 1;

    // Write/done monitor sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ram_we === 1'b1 && wr_cnt < 64) begin
            wr_addr[wr_cnt] = ram_addr;
            wr_data[wr_cnt] = ram_wdata;
            wr_cyc[wr_cnt]  = cyc;
            wr_cs[wr_cnt]   = spi_cs_n;
            wr_cnt = wr_cnt + 1;
        end
        if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
        done_q = done;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (spi_cs_n !== 1'b1)    begin bad++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
        total++; if (spi_sck !== 1'b0)     begin bad++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
        total++; if (spi_mosi !== 1'b0)    begin bad++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
        total++; if (ram_we !== 1'b0)      begin bad++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        total++; if (ram_addr !== 13'd0)   begin bad++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
        total++; if (ram_wdata !== 16'h0)  begin bad++; $display("FAIL reset_wdata got=%h exp=0", ram_wdata); end
        total++; if (cpu_resetq !== 1'b0)  begin bad++; $display("FAIL reset_cpu_resetq got=%b exp=0", cpu_resetq); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_wake_gap(input int mosi_base);
        int hi;
        @(negedge clk);
        resetq = 1'b1;
        for (int i = 0; i < 100 && spi_cs_n !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 100 && spi_cs_n !== 1'b1; i++) @(negedge clk);
        hi = 0;
        while (spi_cs_n === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        #1;
        total++; if (hi !== 8) begin bad++; $display("FAIL wake_gap_len got=%0d exp=8", hi); end
        total++; if (mosi_log[mosi_base] !== 8'hAB) begin bad++; $display("FAIL wake_opcode got=%h exp=ab", mosi_log[mosi_base]); end
    endtask

    task automatic test_first_load(input int mosi_base, input int wr_base);
        logic [7:0] exp_cmd [0:3];
        int edges;
        exp_cmd[0] = 8'h03; exp_cmd[1] = 8'h02; exp_cmd[2] = 8'h00; exp_cmd[3] = 8'h00;
        for (int i = 0; i < 1000 && done !== 1'b1; i++) @(negedge clk);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL load_timeout done=%b exp=1", done); end
        total++; if (mosi_cnt - mosi_base !== 5) begin bad++; $display("FAIL cmd_byte_count got=%0d exp=5", mosi_cnt - mosi_base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mosi_log[mosi_base + 1 + i] !== exp_cmd[i]) begin
                bad++; $display("FAIL cmd_byte%0d got=%h exp=%h", i, mosi_log[mosi_base + 1 + i], exp_cmd[i]);
            end
        end
        total++; if (wr_cnt - wr_base !== 4) begin bad++; $display("FAIL write_count got=%0d exp=4", wr_cnt - wr_base); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr[wr_base + i] !== 13'(i) || wr_data[wr_base + i] !== exp_word[i]) begin
                bad++; $display("FAIL write%0d got=%h:%h exp=%h:%h", i, wr_addr[wr_base + i], wr_data[wr_base + i], i, exp_word[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (wr_cyc[wr_base + i] - wr_cyc[wr_base + i - 1] !== 32) begin
                bad++; $display("FAIL write_spacing%0d got=%0d exp=32", i, wr_cyc[wr_base + i] - wr_cyc[wr_base + i - 1]);
            end
        end
        total++; if (wr_cs[wr_base + 3] !== 1'b1) begin bad++; $display("FAIL cs_after_last got=%b exp=1", wr_cs[wr_base + 3]); end
        total++; if (done_rise_cyc - wr_cyc[wr_base + 3] !== 1) begin bad++; $display("FAIL finish_len got=%0d exp=1", done_rise_cyc - wr_cyc[wr_base + 3]); end
        total++; if (cpu_resetq !== 1'b1) begin bad++; $display("FAIL run_cpu_resetq got=%b exp=1", cpu_resetq); end
        edges = sck_edges;
        repeat (20) @(negedge clk);
        #1;
        total++; if (sck_edges !== edges) begin bad++; $display("FAIL run_sck_edges got=%0d exp=%0d", sck_edges, edges); end
        total++; if (spi_cs_n !== 1'b1 || ram_we !== 1'b0 || wr_cnt - wr_base !== 4) begin
            bad++; $display("FAIL run_idle got=cs%b we%b n%0d exp=cs1 we0 n4", spi_cs_n, ram_we, wr_cnt - wr_base);
        end
    endtask

    task automatic test_reload();
        int wr_base, mosi_base;
        wr_base = wr_cnt;
        mosi_base = mosi_cnt;
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
        #1;
        total++; if (cpu_resetq !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reload_drop got=cpu%b done%b exp=cpu0 done0", cpu_resetq, done);
        end
        total++; if (ram_addr !== 13'd0) begin bad++; $display("FAIL reload_addr got=%h exp=0", ram_addr); end
        for (int i = 0; i < 1000 && wr_cnt == wr_base; i++) @(negedge clk);
        // First word written: the loader is in DATA, so this request must be dropped.
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
        for (int i = 0; i < 1000 && done !== 1'b1; i++) @(negedge clk);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL reload_timeout done=%b exp=1", done); end
        total++; if (wr_cnt - wr_base !== 4 || mosi_cnt - mosi_base !== 5) begin
            bad++; $display("FAIL reload_counts got=w%0d c%0d exp=w4 c5", wr_cnt - wr_base, mosi_cnt - mosi_base);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr[wr_base + i] !== 13'(i) || wr_data[wr_base + i] !== exp_word[i]) begin
                bad++; $display("FAIL reload_write%0d got=%h:%h exp=%h:%h", i, wr_addr[wr_base + i], wr_data[wr_base + i], i, exp_word[i]);
            end
        end
        repeat (40) @(negedge clk);
        #1;
        total++; if (done !== 1'b1 || wr_cnt - wr_base !== 4) begin
            bad++; $display("FAIL reload_not_queued got=done%b n%0d exp=done1 n4", done, wr_cnt - wr_base);
        end
    endtask

    task automatic test_reset_midload();
        int wr_base;
        wr_base = wr_cnt;
        reload_req = 1'b1;
        @(negedge clk);
        reload_req = 1'b0;
        for (int i = 0; i < 1000 && wr_cnt == wr_base; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        resetq = 1'b0;
        #1;
        total++; if (spi_cs_n !== 1'b1 || cpu_resetq !== 1'b0 || ram_addr !== 13'd0) begin
            bad++; $display("FAIL abort got=cs%b cpu%b addr%h exp=cs1 cpu0 addr0", spi_cs_n, cpu_resetq, ram_addr);
        end
        total++; if (spi_sck !== 1'b0 || ram_we !== 1'b0) begin
            bad++; $display("FAIL abort_bus got=sck%b we%b exp=sck0 we0", spi_sck, ram_we);
        end
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        wr_base = wr_cnt;
        for (int i = 0; i < 1000 && done !== 1'b1; i++) @(negedge clk);
        #1;
        total++; if (done !== 1'b1 || wr_cnt - wr_base !== 4) begin
            bad++; $display("FAIL restart got=done%b n%0d exp=done1 n4", done, wr_cnt - wr_base);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_addr[wr_base + i] !== 13'(i) || wr_data[wr_base + i] !== exp_word[i]) begin
                bad++; $display("FAIL restart_write%0d got=%h:%h exp=%h:%h", i, wr_addr[wr_base + i], wr_data[wr_base + i], i, exp_word[i]);
            end
        end
    endtask

    initial begin
        int mosi_base, wr_base;
        flash_mem[0] = 8'h34; flash_mem[1] = 8'h12; flash_mem[2] = 8'h78; flash_mem[3] = 8'h56;
        flash_mem[4] = 8'hBC; flash_mem[5] = 8'h9A; flash_mem[6] = 8'hF0; flash_mem[7] = 8'hDE;
        exp_word[0] = 16'h1234; exp_word[1] = 16'h5678; exp_word[2] = 16'h9ABC; exp_word[3] = 16'hDEF0;
        test_reset();
        mosi_base = mosi_cnt;
        wr_base = wr_cnt;
        test_wake_gap(mosi_base);
        test_first_load(mosi_base, wr_base);
        test_reload();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
